// File: rtl/prog_loader.sv
// Programming-port initiator for the RAM: LOAD streams DEPTH bytes from a
// valid/ready source into addresses 0..DEPTH-1, DUMP reads them back to a sink.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_value,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (abort) begin
      // A write in flight still commits: mem_we is high up to this edge.
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          if (start_load)      r_state <= S_LOAD;
          else if (start_dump) r_state <= S_DUMP_RD;
        end
        S_LOAD: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_addr == LAST) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_DUMP_RD: begin
          r_data  <= mem_rdata;
          r_state <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (out_ready) begin
            if (r_addr == LAST) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_DUMP_RD;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_sel   = busy;
  assign mem_addr  = r_addr;
  assign mem_we    = (r_state == S_WRITE);
  assign mem_value = (r_state == S_WRITE) ? r_data : '0;
  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_DUMP_OUT);
  assign out_data  = r_data;
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a behavioural RAM on the manual port.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_load = 1'b0, start_dump = 1'b0, abort = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, mem_sel, mem_we, busy, done;
  logic [7:0] out_data, mem_value, mem_rdata;
  logic [3:0] mem_addr;

  logic [7:0] ram [16];
  logic [7:0] img1 [16];
  logic [7:0] ld_img [16];

  int checks = 0;
  int failures = 0;

  // do_load results
  int we_cnt, we_bad, gap_we, gap_hold_bad, done_cyc, out_seen;

  prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_value(mem_value),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_sel && mem_we) ram[mem_addr] <= mem_value;
  assign mem_rdata = ram[mem_addr];

  // Streams ld_img; optional 5-cycle source gap after byte 3, optional
  // start_dump pokes while busy (start_dump also raised with start_load).
  task automatic do_load(input int gap_len, input bit poke);
    int idx, gap, gc, cyc;
    bit acc, in_gap;
    we_cnt = 0; we_bad = 0; gap_we = 0; gap_hold_bad = 0; done_cyc = -1;
    out_seen = 0; idx = 0; gap = 0; gc = 0; cyc = 0; acc = 0;
    @(posedge clk); #1;
    start_load = 1; start_dump = poke; in_valid = 1; in_data = ld_img[0];
    for (int n = 0; n < 120 && done_cyc < 0; n++) begin
      @(posedge clk); #1;
      start_load = 0;
      start_dump = poke && (cyc % 3 == 1);
      cyc++;
      if (acc) begin
        idx++;
        if (idx == 4 && gap_len > 0) begin gap = gap_len; gc = 0; end
      end
      in_gap = (gap > 0);
      if (in_gap) begin gap--; gc++; end
      in_valid = (idx < 16) && !in_gap;
      in_data  = (idx < 16) ? ld_img[idx] : 8'h00;
      @(negedge clk);
      if (mem_we) begin
        if (we_cnt >= 16 || mem_addr != we_cnt[3:0] || mem_value != ld_img[we_cnt[3:0]])
          we_bad++;
        we_cnt++;
        if (in_gap && gc > 1) gap_we++;
      end
      if (in_gap && gc > 1 && !in_ready) gap_hold_bad++;
      if (out_valid) out_seen++;
      if (done) done_cyc = cyc;
      acc = in_valid && in_ready;
    end
    start_dump = 0; in_valid = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    #12;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (mem_sel !== 1'b0) begin failures++; $display("FAIL rst_mem_sel got=%b exp=0", mem_sel); end
    checks++; if (mem_we !== 1'b0)  begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if ({in_ready, out_valid, done} !== 3'b000)
      begin failures++; $display("FAIL rst_flags got=%b exp=000", {in_ready, out_valid, done}); end
    checks++; if ({mem_addr, mem_value, out_data} !== 20'h0)
      begin failures++; $display("FAIL rst_data got=%h exp=0", {mem_addr, mem_value, out_data}); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_reset_mid_load;
    bit hit = 0;
    @(posedge clk); #1;
    start_load = 1; in_valid = 1; in_data = 8'h33;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(posedge clk); #1; start_load = 0;
      @(negedge clk);
      if (mem_we && mem_addr == 4'd7) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL midrst_reach got=0 exp=1"); end
    #2 rst = 0;
    #1;
    checks++; if ({mem_sel, mem_we} !== 2'b00)
      begin failures++; $display("FAIL midrst_async got=%b exp=00", {mem_sel, mem_we}); end
    in_valid = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    checks++; if ({busy, mem_sel, mem_addr} !== 6'h0)
      begin failures++; $display("FAIL midrst_idle got=%h exp=0", {busy, mem_sel, mem_addr}); end
  endtask

  task automatic test_full_load;
    for (int i = 0; i < 16; i++) ld_img[i] = img1[i];
    do_load(0, 0);
    checks++; if (we_cnt != 16) begin failures++; $display("FAIL load_we_count got=%0d exp=16", we_cnt); end
    checks++; if (we_bad != 0)  begin failures++; $display("FAIL load_we_addr_val got=%0d bad exp=0", we_bad); end
    checks++; if (done_cyc != 33) begin failures++; $display("FAIL load_done_cycle got=%0d exp=33", done_cyc); end
    @(posedge clk); #1;
    checks++; if ({done, busy, mem_sel} !== 3'b000)
      begin failures++; $display("FAIL load_after_done got=%b exp=000", {done, busy, mem_sel}); end
    checks++; if (ram[8] !== 8'h00) begin failures++; $display("FAIL load_ram8 got=%h exp=00", ram[8]); end
    checks++; if (ram[15] !== 8'h02) begin failures++; $display("FAIL load_ram15 got=%h exp=02", ram[15]); end
  endtask

  task automatic test_dump_backpressure;
    int k = 0, beats = 0, dn = 0, seq_bad = 0, stall_bad = 0, stalls = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = '0;
    @(posedge clk); #1; start_dump = 1;
    for (int n = 0; n < 200 && dn == 0; n++) begin
      @(posedge clk); #1;
      start_dump = 0;
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      k++;
      @(negedge clk);
      if (out_valid) begin
        if (prev_stall && out_data !== prev_data) stall_bad++;
        if (out_ready) begin
          if (beats >= 16 || out_data !== img1[beats[3:0]]) seq_bad++;
          beats++;
        end else stalls++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) dn++;
    end
    out_ready = 0;
    checks++; if (beats != 16) begin failures++; $display("FAIL dump_beats got=%0d exp=16", beats); end
    checks++; if (seq_bad != 0) begin failures++; $display("FAIL dump_sequence got=%0d bad exp=0", seq_bad); end
    checks++; if (stall_bad != 0 || stalls == 0)
      begin failures++; $display("FAIL dump_stall_stable got=%0d bad/%0d stalls exp=0/>0", stall_bad, stalls); end
    @(posedge clk); #1;
    checks++; if ({dn[1:0], done, busy} !== 4'b0100)
      begin failures++; $display("FAIL dump_done_pulse got=%b exp=0100", {dn[1:0], done, busy}); end
  endtask

  task automatic test_source_gap;
    for (int i = 0; i < 16; i++) ld_img[i] = 8'hA0 + 8'(i);
    do_load(5, 0);
    checks++; if (gap_we != 0 || gap_hold_bad != 0)
      begin failures++; $display("FAIL gap_hold got=%0d we/%0d drop exp=0/0", gap_we, gap_hold_bad); end
    checks++; if (we_cnt != 16 || we_bad != 0 || done_cyc < 0)
      begin failures++; $display("FAIL gap_writes got=%0d/%0d bad exp=16/0", we_cnt, we_bad); end
    checks++; if (ram[4] !== 8'hA4) begin failures++; $display("FAIL gap_ram4 got=%h exp=a4", ram[4]); end
  endtask

  task automatic test_abort;
    bit hit = 0;
    int dn = 0;
    @(posedge clk); #1;
    start_load = 1; in_valid = 1; in_data = 8'h50;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(posedge clk); #1;
      start_load = 0;
      if (!in_ready) in_data = 8'h50 + {4'h0, mem_addr} + 8'h01;
      @(negedge clk);
      if (done) dn++;
      if (mem_we && mem_addr == 4'd5) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL abort_reach got=0 exp=1"); end
    abort = 1;
    @(posedge clk); #1;
    abort = 0; in_valid = 0;
    checks++; if ({busy, mem_sel, done} !== 3'b000)
      begin failures++; $display("FAIL abort_idle got=%b exp=000", {busy, mem_sel, done}); end
    repeat (4) begin
      @(negedge clk);
      if (done || mem_we) dn++;
    end
    checks++; if (dn != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
    checks++; if (ram[5] !== 8'h55) begin failures++; $display("FAIL abort_ram5 got=%h exp=55", ram[5]); end
    checks++; if (ram[6] !== 8'hA6) begin failures++; $display("FAIL abort_ram6 got=%h exp=a6", ram[6]); end
    @(posedge clk); #1; start_dump = 1;
    @(posedge clk); #1; start_dump = 0;
    checks++; if ({mem_sel, mem_we, mem_addr} !== 6'b10_0000)
      begin failures++; $display("FAIL abort_dump_addr got=%b exp=100000", {mem_sel, mem_we, mem_addr}); end
    @(posedge clk); #1;
    checks++; if (!out_valid || out_data !== 8'h50)
      begin failures++; $display("FAIL abort_dump_first got=%b/%h exp=1/50", out_valid, out_data); end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    checks++; if ({busy, out_valid} !== 2'b00)
      begin failures++; $display("FAIL abort_dump_idle got=%b exp=00", {busy, out_valid}); end
  endtask

  task automatic test_back_to_back;
    int after = 0;
    for (int i = 0; i < 16; i++) ld_img[i] = img1[i];
    do_load(0, 1);
    checks++; if (we_cnt != 16 || we_bad != 0 || done_cyc != 33 || out_seen != 0)
      begin failures++; $display("FAIL both_start_load got=%0d/%0d/%0d/%0d exp=16/0/33/0",
                                 we_cnt, we_bad, done_cyc, out_seen); end
    repeat (6) begin
      @(negedge clk);
      if (busy || mem_sel || out_valid) after++;
    end
    checks++; if (after != 0) begin failures++; $display("FAIL busy_start_ignored got=%0d exp=0", after); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    img1[0] = 8'h18; img1[1] = 8'h28; img1[2] = 8'hE0; img1[3] = 8'h75;
    img1[4] = 8'h61; img1[5] = 8'hF0;
    for (int i = 6; i < 15; i++) img1[i] = 8'h00;
    img1[15] = 8'h02;
    test_reset;
    test_reset_mid_load;
    test_full_load;
    test_dump_backpressure;
    test_source_gap;
    test_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
